// File: rtl/rx_fcs_strip_if.sv
// Byte stream and result signals between the MAC-PHY RX path, the FCS
// stripper, and the RX FIFO / RX Controller.
interface rx_fcs_strip_if #(
    parameter int LEN_WIDTH = 16
);
    logic                 fcsEnable;
    logic                 rxStart_p;
    logic                 rxAbort_p;
    logic [7:0]           rxDIn;
    logic                 rxDInValid;
    logic                 rxDInLast;
    logic                 rxFifoFull;
    logic [7:0]           rxDOut;
    logic                 rxDOutValid;
    logic                 rxBusy;
    logic                 rxDone_p;
    logic                 rxFcsOk;
    logic                 rxFcsErr;
    logic [LEN_WIDTH-1:0] rxLength;

    modport master (
        output fcsEnable, rxStart_p, rxAbort_p, rxDIn, rxDInValid, rxDInLast, rxFifoFull,
        input  rxDOut, rxDOutValid, rxBusy, rxDone_p, rxFcsOk, rxFcsErr, rxLength
    );

    modport slave (
        input  fcsEnable, rxStart_p, rxAbort_p, rxDIn, rxDInValid, rxDInLast, rxFifoFull,
        output rxDOut, rxDOutValid, rxBusy, rxDone_p, rxFcsOk, rxFcsErr, rxLength
    );
endinterface

// File: rtl/rx_fcs_strip.sv
// RX FCS stripper: CRC-32 over every received byte, forwards the body delayed
// by four bytes so the trailing FCS is never emitted, and reports the result.
module rx_fcs_strip #(
    parameter logic [31:0] CRC_POLYNOMIAL    = 32'h04C1_1DB7,
    parameter logic [31:0] CRC_PRELOAD_VALUE = 32'hFFFF_FFFF,
    parameter logic [31:0] CRC_RESULT        = 32'hC704_DD7B,
    parameter int          LEN_WIDTH         = 16
) (
    input  logic          macCoreClk,
    input  logic          macCoreClkHardRst_n,
    rx_fcs_strip_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t               r_state;
    logic [31:0]          r_crc;
    logic [7:0]           r_buf [4];
    logic [2:0]           r_count;
    logic [7:0]           r_dout;
    logic                 r_dout_valid;
    logic                 r_done;
    logic                 r_ok;
    logic                 r_err;
    logic [LEN_WIDTH-1:0] r_len;

    logic                 w_accept;
    logic                 w_take;
    logic [31:0]          w_crc_base;
    logic [31:0]          w_crc_next;
    logic [2:0]           w_count_base;
    logic                 w_ok;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        // NOTE: blocking assignments here are intentional; each bit step feeds the next within one cycle.
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = {c[30:0], 1'b0} ^ (CRC_POLYNOMIAL & {32{d[i] ^ c[31]}});
        end
        return c;
    endfunction

    assign w_accept     = bus.rxDInValid && !bus.rxFifoFull && (r_state == FILL || r_state == STREAM);
    // A start in the same cycle restarts the frame with this byte; a lone abort drops it.
    assign w_take       = w_accept && (bus.rxStart_p || !bus.rxAbort_p);
    assign w_crc_base   = bus.rxStart_p ? CRC_PRELOAD_VALUE : r_crc;
    assign w_count_base = bus.rxStart_p ? 3'd0 : r_count;
    assign w_crc_next   = crc_byte(w_crc_base, bus.rxDIn);
    assign w_ok         = (w_crc_next == CRC_RESULT) && (w_count_base == 3'd4);

    always_ff @(posedge macCoreClk or negedge macCoreClkHardRst_n) begin
        if (!macCoreClkHardRst_n) begin
            r_state      <= IDLE;
            r_crc        <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_done       <= 1'b0;
            r_ok         <= 1'b0;
            r_err        <= 1'b0;
            r_len        <= '0;
        end else if (!bus.fcsEnable) begin
            r_state      <= IDLE;
            r_crc        <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_done       <= 1'b0;
            r_ok         <= 1'b0;
            r_err        <= 1'b0;
            r_len        <= '0;
        end else begin
            r_dout_valid <= 1'b0;
            r_done       <= 1'b0;

            if (bus.rxStart_p) begin
                r_state <= FILL;
                r_crc   <= CRC_PRELOAD_VALUE;
                r_count <= '0;
                r_ok    <= 1'b0;
                r_err   <= 1'b0;
                r_len   <= '0;
            end else if (bus.rxAbort_p) begin
                r_state <= IDLE;
                r_crc   <= '0;
                r_count <= '0;
                r_dout  <= '0;
                r_ok    <= 1'b0;
                r_err   <= 1'b0;
                r_len   <= '0;
            end else if (r_state == DONE) begin
                r_state <= IDLE;
                r_count <= '0;
            end

            if (w_take) begin
                r_crc <= w_crc_next;
                if (w_count_base == 3'd4) begin
                    r_dout       <= r_buf[3];
                    r_dout_valid <= 1'b1;
                    if (!(&r_len)) begin
                        r_len <= r_len + LEN_WIDTH'(1);
                    end
                end else begin
                    r_count <= w_count_base + 3'd1;
                end

                if (bus.rxDInLast) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    r_ok    <= w_ok;
                    r_err   <= !w_ok;
                end else if (w_count_base >= 3'd3) begin
                    r_state <= STREAM;
                end else begin
                    r_state <= FILL;
                end
            end
        end
    end

    // NOTE: the delay line has no reset; r_count alone says which entries are meaningful.
    always_ff @(posedge macCoreClk) begin
        if (w_take) begin
            r_buf[0] <= bus.rxDIn;
            r_buf[1] <= r_buf[0];
            r_buf[2] <= r_buf[1];
            r_buf[3] <= r_buf[2];
        end
    end

    assign bus.rxDOut      = r_dout;
    assign bus.rxDOutValid = r_dout_valid;
    assign bus.rxBusy      = bus.fcsEnable && bus.rxFifoFull;
    assign bus.rxDone_p    = r_done;
    assign bus.rxFcsOk     = r_ok;
    assign bus.rxFcsErr    = r_err;
    assign bus.rxLength    = r_len;
endmodule
